// File: rtl/cache_arbiter_if.sv
// Line-port bundle between the two caches, the arbiter and main memory.
// slave = arbiter view, master = environment (caches + memory) view.
interface cache_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Shares one line-wide memory port between I-cache and D-cache, one transaction
// at a time; D has priority, bounded by a streak limit so a waiting I is never starved.
module cache_arbiter #(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  logic [1:0]        state;
  logic [SW-1:0]     streak;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              i_pend;
  logic              d_pend;
  logic              grant_d;
  logic              grant_i;
  logic              busy;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(MAX_D_STREAK)) ? v : v + 1'b1;
  endfunction

  // D wins unless I has already waited through MAX_D_STREAK consecutive D grants.
  always_comb begin
    i_pend  = bus.i_pmem_read;
    d_pend  = bus.d_pmem_read | bus.d_pmem_write;
    grant_d = d_pend && !(i_pend && (streak == SW'(MAX_D_STREAK)));
    grant_i = i_pend && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      streak   <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= SERVE_D;
            op_write <= bus.d_pmem_write;
            addr_q   <= bus.d_pmem_address;
            wdata_q  <= bus.d_pmem_wdata;
            streak   <= i_pend ? sat_inc(streak) : '0;
          end else if (grant_i) begin
            state    <= SERVE_I;
            op_write <= 1'b0;
            addr_q   <= bus.i_pmem_address;
            streak   <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.pmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is routed combinationally so the cache sees resp in the memory's cycle.
  always_comb begin
    busy             = (state != IDLE);
    bus.pmem_read    = busy & ~op_write;
    bus.pmem_write   = busy & op_write;
    bus.pmem_address = addr_q;
    bus.pmem_wdata   = wdata_q;
    bus.i_pmem_resp  = (state == SERVE_I) & bus.pmem_resp;
    bus.d_pmem_resp  = (state == SERVE_D) & bus.pmem_resp;
    bus.i_pmem_rdata = bus.pmem_rdata;
    bus.d_pmem_rdata = bus.pmem_rdata;
  end

endmodule
